grf_wport_arbiter: RTL
======================

Name: grf_wport_arbiter

Overview:
Shares the single GRF write port between the pipeline W stage and a long-latency result requester (MDU/CP0 late writeback). W stage always has priority. Late results are buffered in a small FIFO and drained into free write slots. A 32-entry busy scoreboard tracks registers with pending late results, so hazard logic can stall readers.

Parameters:
DEPTH, 4, late-result FIFO entries; power of 2, at least 2
STARVE_LIMIT, 8, cycles a FIFO head may wait before the guard acts (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all state
w_we  in  1  W stage write request (no backpressure)
w_addr  in  5  W stage destination register
w_data  in  32  W stage write data
a_valid  in  1  late requester holds a result
a_ready  out  1  FIFO can accept; equals !full
a_addr  in  5  late result destination
a_data  in  32  late result data
rsv_valid  in  1  a long-latency op is issued; mark rsv_addr busy
rsv_addr  in  5  register to reserve
rd_addr1  in  5  busy query address 1
rd_addr2  in  5  busy query address 2
rd_busy1  out  1  rd_addr1 has a pending late write (combinational)
rd_busy2  out  1  rd_addr2 has a pending late write (combinational)
grf_we  out  1  to GRF WEn
grf_addr  out  5  to GRF AddrW
grf_wdata  out  32  to GRF WData
fifo_cnt  out  clog2(DEPTH)+1  current FIFO occupancy
stall_w  out  1  hold W stage one cycle (0 unless the optional feature is enabled)

Behaviour:
- Reset (asynchronous): FIFO empty, fifo_cnt=0, busy vector all 0, a_ready=1, grf_we=0, stall_w=0, starvation counter=0.
- Accept: when a_valid && a_ready at a rising edge, push {a_addr,a_data}. a_ready depends only on !full; a pop in the same cycle does not let a push into a full FIFO.
- Write-port mux (combinational):
  - w_we=1 and w_addr!=0: drive the W-stage write.
  - Otherwise, FIFO non-empty: drive the FIFO head and pop at the edge.
  - Otherwise: grf_we=0.
- Latency: a late result accepted at edge N reaches the GRF port during cycle N+1 at the earliest, and is written at edge N+1.
- Register 0: a W-stage write to $0 counts as idle (the FIFO may drain that cycle). A FIFO entry addressed to $0 pops with grf_we=0.
- Push and pop in the same cycle: fifo_cnt stays the same. Pointers wrap modulo DEPTH.
- Scoreboard: rsv_valid at an edge sets busy[rsv_addr], except for $0. A FIFO pop of address r clears busy[r]. If set and clear hit the same register in the same cycle, set wins.
- Busy queries: rd_busyX = busy[rd_addrX]. $0 always reads 0. There is no bypass of in-flight FIFO data.
- Protocol rule: at most one outstanding reservation per register. Reserving a register that is already busy is illegal, and the behaviour is undefined.
- Reset mid-operation drops all buffered entries and reservations immediately.

Optional Feature:
Macro: GRF_ARB_STARVE_GUARD_EN.
- Enabled:
  - A counter increments each cycle the FIFO is non-empty and the head is not popped. It resets to 0 on a pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, stall_w=1 for exactly one cycle. In that cycle the FIFO head is written even if w_we=1, and the counter resets.
  - The upstream pipeline must hold the W-stage write and re-present it the next cycle.
- Disabled: stall_w is tied to 0 and no counter exists. The W stage can starve the FIFO indefinitely.

Test Plan:
1. Reset, then w_we=1, w_addr=1, w_data=15 for one cycle -> grf_we=1, grf_addr=1, grf_wdata=15 in that cycle; fifo_cnt=0.
2. rsv_valid with rsv_addr=2; next cycle push a_addr=2, a_data=22 with w_we=0 -> rd_busy1 (rd_addr1=2) reads 1 until the edge after the push; grf_we=1, addr=2, data=22 one cycle after accept; busy[2] then 0.
3. Hold w_we=1 (addr 3) while pushing 4 late results -> fifo_cnt reaches 4 and a_ready=0; drop w_we -> entries drain in order, one per cycle; a_ready=1 after the first pop.
4. Same cycle: rsv_valid addr=5 and FIFO pop of addr 5 -> busy[5] stays 1.
5. FIFO entry with a_addr=0 and w_we=0 -> the entry pops with grf_we=0; busy is unchanged.
6. With GRF_ARB_STARVE_GUARD_EN and STARVE_LIMIT=8, hold w_we=1 with one entry buffered -> stall_w=1 in the 9th cycle after accept, the head is written that cycle, then stall_w=0. Without the macro, stall_w stays 0 throughout.

Source files
------------

// File: rtl/grf_wport_arbiter.sv
// grf_wport_arbiter: arbitrates the single GRF write port between the W stage
// (always preferred) and late results (MDU/CP0) that are buffered in a small FIFO.
// A 32-entry busy scoreboard marks registers that still have a late write pending.
// Optional build macro GRF_ARB_STARVE_GUARD_EN enables a starvation guard. The guard
// stalls the W stage for one cycle so that a FIFO head that has waited
// STARVE_LIMIT cycles can be written.
module grf_wport_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_we,
  input  logic [4:0]                 w_addr,
  input  logic [31:0]                w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [4:0]                 a_addr,
  input  logic [31:0]                a_data,
  input  logic                       rsv_valid,
  input  logic [4:0]                 rsv_addr,
  input  logic [4:0]                 rd_addr1,
  input  logic [4:0]                 rd_addr2,
  output logic                       rd_busy1,
  output logic                       rd_busy2,
  output logic                       grf_we,
  output logic [4:0]                 grf_addr,
  output logic [31:0]                grf_wdata,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic                       stall_w
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          w_win;
  logic          stall;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign push      = a_valid && !full;
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign a_ready   = !full;
  assign fifo_cnt  = cnt;
  assign stall_w   = stall;

`ifdef GRF_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign stall = !empty && (starve_cnt == SW'(STARVE_LIMIT));

  // Count cycles the current head has waited without being popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // Write-port mux: W stage wins unless it targets $0 or the guard forces a drain.
  always_comb begin
    w_win     = w_we && (w_addr != '0) && !stall;
    pop       = !empty && !w_win;
    grf_we    = 1'b0;
    grf_addr  = head_addr;
    grf_wdata = head_data;
    if (w_win) begin
      grf_we    = 1'b1;
      grf_addr  = w_addr;
      grf_wdata = w_data;
    end else if (pop) begin
      grf_we    = (head_addr != '0);
    end
  end

  // FIFO storage; contents need no reset since cnt gates their visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= a_addr;
      mem_data[wr_ptr] <= a_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Scoreboard next state: clear on pop first so a same-cycle reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (pop && (head_addr != '0)) busy_nxt[head_addr] = 1'b0;
    if (rsv_valid && (rsv_addr != '0)) busy_nxt[rsv_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Busy queries; $0 never reports busy.
  always_comb begin
    rd_busy1 = (rd_addr1 != '0) && busy[rd_addr1];
    rd_busy2 = (rd_addr2 != '0) && busy[rd_addr2];
  end

endmodule
